cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-service responder for the I-cache and D-cache.
- When a cache reports a miss, the block fetches the whole 16-byte block (8 × 16-bit words) from multi-cycle main memory.
- Returned words are streamed into the cache data array, and the tag array is written on the final beat.
- It drives fsm_busy, which the hazard unit uses to stall the pipeline. One instance per cache.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLOCK, 8, words per cache block; a power of two; block bytes = 2*WORDS_PER_BLOCK
- OFF_W, 3, log2(WORDS_PER_BLOCK); width of the word-offset counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  ADDR_W  byte address of the missing access
- fsm_busy  out  1  miss in service; stalls the requesting stage
- write_data_array  out  1  write one word into the cache data array this cycle
- write_tag_array  out  1  write tag and valid bit for the filled block this cycle
- cache_wr_offset  out  OFF_W  word index within the block for write_data_array
- cache_wr_data  out  DATA_W  word to write; equals memory_data
- memory_address  out  ADDR_W  read address to main memory
- memory_rd_en  out  1  issue a read to main memory this cycle
- memory_data  in  DATA_W  read data from main memory
- memory_data_valid  in  1  memory_data is valid this cycle

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; issue_cnt = 0; recv_cnt = 0; base = 0.
  - All outputs are 0 while in reset and in IDLE without a miss.
- States: IDLE, FILL. The state is held in a register.
- IDLE:
  - fsm_busy = miss_detected. This is combinational, so the stall is asserted in the same cycle as the miss.
  - On a rising edge with miss_detected = 1:
    - base <= miss_address with its low log2(2*WORDS_PER_BLOCK) bits cleared.
    - issue_cnt <= 0; recv_cnt <= 0; state <= FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy = 1.
  - Request issue:
    - Active while issue_done = 0.
    - memory_rd_en = 1; memory_address = base + (issue_cnt << 1).
    - issue_cnt increments each cycle.
    - When issue_cnt = WORDS_PER_BLOCK-1 is issued, issue_done <= 1 and memory_rd_en stays 0 for the rest of the fill.
    - Exactly WORDS_PER_BLOCK requests are issued, in ascending word order.
  - Response handling:
    - When memory_data_valid = 1: write_data_array = 1, cache_wr_offset = recv_cnt, cache_wr_data = memory_data. These are combinational, with zero latency from the beat.
    - recv_cnt then increments.
    - Responses are assumed to return in issue order; recv_cnt is the only offset source.
  - Completion:
    - The beat with recv_cnt = WORDS_PER_BLOCK-1 also asserts write_tag_array = 1 in the same cycle.
    - state <= IDLE at that edge; counters clear.
    - fsm_busy drops the following cycle.
- Timing (memory read latency 4 cycles, miss seen in cycle t=0):
  - Requests are issued in t=1..8, at base, base+2, …, base+14.
  - Beats arrive in t=5..12; write_tag_array is asserted at t=12.
  - fsm_busy is high for t=0..12; the block is back in IDLE at t=13 (13 busy cycles).
- Boundary conditions:
  - miss_detected during FILL is ignored; miss_address is not re-sampled.
  - memory_data_valid in IDLE, or any beat beyond the 8th, produces no write.
  - Back-to-back misses: a miss asserted in the cycle after completion (t=13) starts a new fill, with busy high again at t=13.
  - Overlap: a beat may arrive while requests are still issuing (latency < 8); the issue and receive counters are independent.
  - Address wrap: base + 14 computed at address 0xFFF0 yields 0xFFFE. No carry beyond ADDR_W; adds are modulo 2^ADDR_W.
  - Reset mid-fill: returns to IDLE immediately; no further writes; a partially filled block is left untagged (valid bit never written).
  - memory_data is not registered; the cache array must capture it on the same clock edge.

Decomposition:
- Shared header cpu.vh gains:
  - the state encodings `FILL_IDLE = 1'b0` and `FILL_BUSY = 1'b1`;
  - BLOCK_BYTES = 16;
  - WORDS_PER_BLOCK = 8.
- One natural sub-module, fill_beat_counter: OFF_W-bit counter with clear, increment enable, terminal-count output, and async active-low reset.
  - It is instantiated twice, once as the issue counter and once as the receive counter.
- The next-state logic and output decode stay in cache_fill_fsm.

Test Plan:
- Reset, then hold idle for 5 cycles with miss_detected = 0 → all outputs 0; no memory_rd_en.
- Miss at miss_address = 0x1236, memory latency 4 → memory_address sequence 0x1230, 0x1232, …, 0x123E in t=1..8. Data returned as 0xA000+i produces writes at offsets 0..7 with matching data in t=5..12, write_tag_array only at t=12, fsm_busy high t=0..12 and low at t=13.
- Miss at 0xFFFA → base 0xFFF0; last address 0xFFFE; no wrap to 0x0000 within the block.
- miss_detected held high during a fill plus a new miss at t=13 → the first fill is unaffected, and a second fill starts at t=13 using the t=13 address.
- Spurious memory_data_valid pulses in IDLE, and a 9th beat after the tag write → no write_data_array and no write_tag_array.
- rst_n asserted at t=7 of a fill → outputs 0 asynchronously. After release, a new miss restarts at offset 0 with 8 full beats.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss-fill responder: block geometry
// defaults and the fill state encoding.
package cache_fill_fsm_pkg;

  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_OFF_W           = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int DEF_BLOCK_BYTES     = 2 * DEF_WORDS_PER_BLOCK;

  // IDLE waits for a miss; BUSY covers both request issue and beat return.
  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_BUSY = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache-side and memory-side signals of one fill responder. The master
// modport is the fill FSM; the slave modport is the cache/memory environment.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = cache_fill_fsm_pkg::DEF_ADDR_W,
  parameter int DATA_W = cache_fill_fsm_pkg::DEF_DATA_W,
  parameter int OFF_W  = cache_fill_fsm_pkg::DEF_OFF_W
);

  // Cache lookup side
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;

  // Cache array write side
  logic              write_data_array;
  logic              write_tag_array;
  logic [OFF_W-1:0]  cache_wr_offset;
  logic [DATA_W-1:0] cache_wr_data;

  // Main memory side
  logic [ADDR_W-1:0] memory_address;
  logic              memory_rd_en;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, write_data_array, write_tag_array, cache_wr_offset,
           cache_wr_data, memory_address, memory_rd_en
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, write_data_array, write_tag_array, cache_wr_offset,
           cache_wr_data, memory_address, memory_rd_en
  );

endinterface

// File: rtl/cache_fill_fsm_fill_beat_counter.sv
// Word-offset counter used for both the request-issue and the beat-receive
// sides of a block fill. Clear has priority over increment.
module fill_beat_counter #(
  parameter int OFF_W = cache_fill_fsm_pkg::DEF_OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             incr,
  output logic [OFF_W-1:0] count,
  output logic             terminal
);

  // Offset register: clear, else step by one when enabled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + OFF_W'(1);
    end
  end

  // Last word of the block.
  assign terminal = &count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-service responder: on a cache miss, fetch the whole block from
// multi-cycle memory, stream each returned word into the data array and
// write the tag on the final beat. fsm_busy stalls the requesting stage.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int OFF_W           = DEF_OFF_W
) (
  input logic             clk,
  input logic             rst_n,
  cache_fill_fsm_if.master bus
);

  localparam int                BYTE_OFF_W = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BASE_MASK  = ~ADDR_W'((1 << BYTE_OFF_W) - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = '0;
  localparam logic [DATA_W-1:0] ZERO_WORD  = '0;
  localparam logic [OFF_W-1:0]  ZERO_OFF   = '0;

  fill_state_e       state;
  logic [ADDR_W-1:0] baseAddr;
  logic              issueDone;

  logic [OFF_W-1:0]  issueCnt;
  logic [OFF_W-1:0]  recvCnt;
  logic              issueLast;
  logic              recvLast;

  logic              inFill;
  logic              issueFire;
  logic              beatFire;
  logic              lastBeat;
  logic              cntClear;
  logic [ADDR_W-1:0] reqAddr;

  assign inFill    = (state == FILL_BUSY);
  assign issueFire = inFill && !issueDone;
  // Beats outside a fill, or after the last beat has moved us to IDLE, are
  // dropped here, which is what keeps stray responses out of the array.
  assign beatFire  = inFill && bus.memory_data_valid;
  assign lastBeat  = beatFire && recvLast;
  // Counters sit at zero whenever idle, so a new fill always starts at word 0.
  assign cntClear  = !inFill || lastBeat;
  // Modulo-2^ADDR_W add: a block at the top of memory never carries out.
  assign reqAddr   = baseAddr + (ADDR_W'(issueCnt) << 1);

  fill_beat_counter #(.OFF_W(OFF_W)) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cntClear),
    .incr     (issueFire),
    .count    (issueCnt),
    .terminal (issueLast)
  );

  fill_beat_counter #(.OFF_W(OFF_W)) u_recv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cntClear),
    .incr     (beatFire),
    .count    (recvCnt),
    .terminal (recvLast)
  );

  // Fill sequencing: capture the block base on a miss, stop issuing after
  // the last request, return to IDLE on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      baseAddr  <= '0;
      issueDone <= 1'b0;
    end else begin
      case (state)
        FILL_IDLE: begin
          if (bus.miss_detected) begin
            baseAddr  <= bus.miss_address & BASE_MASK;
            issueDone <= 1'b0;
            state     <= FILL_BUSY;
          end
        end
        FILL_BUSY: begin
          // miss_detected/miss_address are deliberately not looked at here.
          if (issueFire && issueLast) begin
            issueDone <= 1'b1;
          end
          if (lastBeat) begin
            issueDone <= 1'b0;
            state     <= FILL_IDLE;
          end
        end
        default: begin
          state <= FILL_IDLE;
        end
      endcase
    end
  end

  // Output decode. The stall and the array writes are combinational so the
  // pipeline stalls in the miss cycle and the array captures the unregistered
  // memory word on the same edge it arrives.
  // NOTE: every output gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.memory_rd_en     = 1'b0;
    bus.memory_address   = ZERO_ADDR;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.cache_wr_offset  = ZERO_OFF;
    bus.cache_wr_data    = ZERO_WORD;

    // While reset is held every output reads zero, even with a miss pending.
    if (rst_n) begin
      bus.fsm_busy = inFill || bus.miss_detected;

      if (issueFire) begin
        bus.memory_rd_en   = 1'b1;
        bus.memory_address = reqAddr;
      end

      if (beatFire) begin
        bus.write_data_array = 1'b1;
        bus.cache_wr_offset  = recvCnt;
        bus.cache_wr_data    = bus.memory_data;
        bus.write_tag_array  = lastBeat;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a per-cycle table of driven inputs and
// hand-derived outputs for a 4-cycle-latency memory, plus a mid-fill reset.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic        rdEn;
    logic [15:0] memAddr;
    logic        wda;
    logic        wta;
    logic [2:0]  off;
    logic [15:0] wrData;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idleVec(input logic valid, input logic [15:0] data);
    vec_t v;
    v.miss = 1'b0; v.addr = 16'h0000; v.valid = valid; v.data = data;
    v.busy = 1'b0; v.rdEn = 1'b0; v.memAddr = 16'h0000;
    v.wda = 1'b0; v.wta = 1'b0; v.off = 3'd0; v.wrData = 16'h0000;
    return v;
  endfunction

  // Cycles t=0..12 of one fill with the miss seen at t=0 and latency 4:
  // requests t=1..8, beats t=5..12 carrying dataBase+i, tag write at t=12.
  // holdMiss keeps miss_detected high with a junk address through t=1..12.
  task automatic pushFill(input logic [15:0] missAddr, input logic [15:0] dataBase,
                          input bit holdMiss);
    logic [15:0] base;
    vec_t v;
    base = {missAddr[15:4], 4'h0};
    for (int t = 0; t <= 12; t++) begin
      v = idleVec(1'b0, 16'h0000);
      v.busy = 1'b1;
      if (t == 0) begin
        v.miss = 1'b1;
        v.addr = missAddr;
      end else if (holdMiss) begin
        v.miss = 1'b1;
        v.addr = 16'hDEAD;
      end
      if (t >= 1 && t <= 8) begin
        v.rdEn    = 1'b1;
        v.memAddr = base + 16'(2 * (t - 1));
      end
      if (t >= 5) begin
        v.valid  = 1'b1;
        v.data   = dataBase + 16'(t - 5);
        v.wda    = 1'b1;
        v.off    = 3'(t - 5);
        v.wrData = v.data;
        v.wta    = (t == 12);
      end
      vecs.push_back(v);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    bus.miss_detected     = v.miss;
    bus.miss_address      = v.addr;
    bus.memory_data_valid = v.valid;
    bus.memory_data       = v.data;
  endtask

  task automatic checkOutputs(input vec_t v, input string tag);
    check({tag, " fsm_busy"},         32'(bus.fsm_busy),         32'(v.busy));
    check({tag, " memory_rd_en"},     32'(bus.memory_rd_en),     32'(v.rdEn));
    check({tag, " memory_address"},   32'(bus.memory_address),   32'(v.memAddr));
    check({tag, " write_data_array"}, 32'(bus.write_data_array), 32'(v.wda));
    check({tag, " write_tag_array"},  32'(bus.write_tag_array),  32'(v.wta));
    check({tag, " cache_wr_offset"},  32'(bus.cache_wr_offset),  32'(v.off));
    check({tag, " cache_wr_data"},    32'(bus.cache_wr_data),    32'(v.wrData));
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge, once the combinational decode has settled.
  task automatic runVecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      driveInputs(vecs[i]);
      @(negedge clk);
      checkOutputs(vecs[i], $sformatf("vec%0d", i));
    end
  endtask

  initial begin
    int markRst;
    int markRestart;

    // Idle after reset, then the basic fill at 0x1236.
    for (int i = 0; i < 5; i++) vecs.push_back(idleVec(1'b0, 16'h0000));
    pushFill(16'h1236, 16'hA000, 1'b0);
    vecs.push_back(idleVec(1'b0, 16'h0000));
    // Top-of-memory block: 0xFFF0..0xFFFE, no wrap.
    pushFill(16'hFFFA, 16'hB000, 1'b0);
    vecs.push_back(idleVec(1'b0, 16'h0000));
    // Miss held through a fill, then back-to-back miss at t=13.
    pushFill(16'h2468, 16'hC000, 1'b1);
    pushFill(16'h3456, 16'hD000, 1'b0);
    vecs.push_back(idleVec(1'b0, 16'h0000));
    // Stray beats in IDLE and a 9th beat after the tag write.
    for (int i = 0; i < 3; i++) vecs.push_back(idleVec(1'b1, 16'h5555));
    pushFill(16'h0100, 16'hE000, 1'b0);
    vecs.push_back(idleVec(1'b1, 16'h9999));
    vecs.push_back(idleVec(1'b1, 16'h999A));
    // Fill to be cut off by reset at t=7 (only t=0..6 are applied).
    markRst = vecs.size();
    pushFill(16'h4000, 16'hF000, 1'b0);
    // Restart after reset: leftover beats ignored, then a full fill at word 0.
    markRestart = vecs.size();
    vecs.push_back(idleVec(1'b1, 16'h1111));
    vecs.push_back(idleVec(1'b1, 16'h1112));
    pushFill(16'h4008, 16'h7000, 1'b0);
    vecs.push_back(idleVec(1'b0, 16'h0000));

    // Reset state, including a stray beat while reset is held.
    rst_n = 1'b0;
    driveInputs(idleVec(1'b1, 16'h3333));
    #12;
    checkOutputs(idleVec(1'b1, 16'h3333), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    runVecs(0, markRst + 7);

    // t=7 of the 0x4000 fill: beat arrives, reset asserted mid-cycle.
    @(posedge clk);
    #1;
    driveInputs(vecs[markRst + 7]);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutputs(idleVec(1'b1, vecs[markRst + 7].data), "mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    runVecs(markRestart, vecs.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
